// File: rtl/apb_cmd_master_if.sv
// rtl/apb_cmd_master_if.sv - command, response and APB signal bundle for apb_cmd_master
//
// Purpose: groups the command channel, response channel, status and APB
// requester signals so that the master and its environment connect through one port.
// Ports (master view):
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata : command channel in
//   rsp_valid/rsp_ready/rsp_write/rsp_rdata/rsp_timeout : response channel out
//   busy : FIFO non-empty or a transfer in progress
//   apb_sel/apb_enable/apb_write/apb_addr/apb_wdata : APB requester outputs
//   apb_ready/apb_rdata : APB completer inputs
interface apb_cmd_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_timeout;

  logic              busy;

  logic              apb_sel;
  logic              apb_enable;
  logic              apb_write;
  logic [ADDR_W-1:0] apb_addr;
  logic [DATA_W-1:0] apb_wdata;
  logic              apb_ready;
  logic [DATA_W-1:0] apb_rdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, apb_ready, apb_rdata,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_timeout, busy,
           apb_sel, apb_enable, apb_write, apb_addr, apb_wdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, apb_ready, apb_rdata,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_timeout, busy,
           apb_sel, apb_enable, apb_write, apb_addr, apb_wdata
  );
endinterface

// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - command-driven APB requester with command FIFO and response channel
//
// Purpose: buffers read/write commands in a CMD_DEPTH-entry FIFO, runs each as one
// APB SETUP/ACCESS transfer and returns one response per transfer, in order.
// Optional feature macro: APB_CMD_MASTER_TIMEOUT_EN (ACCESS abort after
// TIMEOUT_CYCLES cycles without apb_ready; otherwise ACCESS waits forever).
// Ports:
//   aclk   : clock, rising edge
//   areset : synchronous active-high reset
//   bus    : apb_cmd_master_if.master (command, response, busy and APB signals)
module apb_cmd_master #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 16,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             aclk,
  input  logic             areset,
  apb_cmd_master_if.master bus
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 1 + ADDR_W + DATA_W;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [ENT_W-1:0]  r_mem [CMD_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [1:0]        r_state;

  logic              r_apb_sel;
  logic              r_apb_enable;
  logic              r_apb_write;
  logic [ADDR_W-1:0] r_apb_addr;
  logic [DATA_W-1:0] r_apb_wdata;

  logic              r_rsp_valid;
  logic              r_rsp_write;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_timeout;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_timeout_hit;
  logic [ENT_W-1:0]  w_head;

  assign w_full  = (r_count == CNT_W'(CMD_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = bus.cmd_valid && !w_full;
  // The head is popped straight into the APB holding registers, either from IDLE
  // or at the response handshake, so the next SETUP follows RESP with no idle gap.
  assign w_pop   = !w_empty &&
                   ((r_state == S_IDLE) || ((r_state == S_RESP) && bus.rsp_ready));
  assign w_head  = r_mem[r_rd_ptr];

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TO_W-1:0] r_to_cnt;

  // Cleared during SETUP so it starts at 0 on the first ACCESS cycle.
  always_ff @(posedge aclk) begin
    if (areset || (r_state == S_SETUP)) begin
      r_to_cnt <= '0;
    end else if ((r_state == S_ACCESS) && !bus.apb_ready) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // apb_ready in the limit cycle is not an abort; completion wins.
  assign w_timeout_hit = (r_state == S_ACCESS) && !bus.apb_ready &&
                         (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_cfg;
  assign w_unused_cfg  = (TIMEOUT_CYCLES != 0);
  assign w_timeout_hit = 1'b0;
`endif

  // FIFO storage carries no reset; entries only become visible through r_count.
  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_state       <= S_IDLE;
      r_apb_sel     <= 1'b0;
      r_apb_enable  <= 1'b0;
      r_apb_write   <= 1'b0;
      r_apb_addr    <= '0;
      r_apb_wdata   <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_write   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            {r_apb_write, r_apb_addr, r_apb_wdata} <= w_head;
            r_apb_sel <= 1'b1;
            r_state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_apb_enable <= 1'b1;
          r_state      <= S_ACCESS;
        end
        S_ACCESS: begin
          if (bus.apb_ready || w_timeout_hit) begin
            r_apb_sel     <= 1'b0;
            r_apb_enable  <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_write   <= r_apb_write;
            r_rsp_rdata   <= (bus.apb_ready && !r_apb_write) ? bus.apb_rdata : '0;
            r_rsp_timeout <= !bus.apb_ready;
            r_state       <= S_RESP;
          end
        end
        default: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (w_pop) begin
              {r_apb_write, r_apb_addr, r_apb_wdata} <= w_head;
              r_apb_sel <= 1'b1;
              r_state   <= S_SETUP;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign bus.cmd_ready   = !w_full;
  assign bus.busy        = !w_empty || (r_state != S_IDLE);
  assign bus.apb_sel     = r_apb_sel;
  assign bus.apb_enable  = r_apb_enable;
  assign bus.apb_write   = r_apb_write;
  assign bus.apb_addr    = r_apb_addr;
  assign bus.apb_wdata   = r_apb_wdata;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_write   = r_rsp_write;
  assign bus.rsp_rdata   = r_rsp_rdata;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
  assign bus.rsp_timeout = r_rsp_timeout;
`else
  assign bus.rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - self-checking bench for apb_cmd_master
module tb_apb_cmd_master;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apb_cmd_master_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  apb_cmd_master #(
    .ADDR_W(8), .DATA_W(16), .CMD_DEPTH(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .aclk(clk),
    .areset(rst),
    .bus(bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] wdata;
    int          waits;
    logic [15:0] cmp_rdata;
    logic [15:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic bound_fail(input string nm);
    n_total++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  task automatic push_cmd(input logic w, input logic [7:0] a, input logic [15:0] d);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    while (!bus.cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) bound_fail("push");
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"},   32'(bus.cmd_ready),   32'd1);
    chk({tag, "_busy"},        32'(bus.busy),        32'd0);
    chk({tag, "_apb_sel"},     32'(bus.apb_sel),     32'd0);
    chk({tag, "_apb_enable"},  32'(bus.apb_enable),  32'd0);
    chk({tag, "_apb_write"},   32'(bus.apb_write),   32'd0);
    chk({tag, "_apb_addr"},    32'(bus.apb_addr),    32'd0);
    chk({tag, "_apb_wdata"},   32'(bus.apb_wdata),   32'd0);
    chk({tag, "_rsp_valid"},   32'(bus.rsp_valid),   32'd0);
    chk({tag, "_rsp_write"},   32'(bus.rsp_write),   32'd0);
    chk({tag, "_rsp_rdata"},   32'(bus.rsp_rdata),   32'd0);
    chk({tag, "_rsp_timeout"}, 32'(bus.rsp_timeout), 32'd0);
  endtask

  // One command through an idle DUT with a completer that inserts v.waits wait states.
  task automatic run_vec(input vec_t v, input int idx);
    int cyc, acc, first_sel;
    bit got;
    string p;
    p = $sformatf("vec%0d", idx);
    bus.rsp_ready = 1'b1;
    bus.apb_ready = 1'b0;
    push_cmd(v.wr, v.addr, v.wdata);
    cyc = 0; acc = 0; first_sel = -1; got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      if (bus.apb_sel && !bus.apb_enable && first_sel < 0) begin
        first_sel = cyc;
        chk({p, "_setup_addr"},  32'(bus.apb_addr),  32'(v.addr));
        chk({p, "_setup_write"}, 32'(bus.apb_write), 32'(v.wr));
        if (v.wr) chk({p, "_setup_wdata"}, 32'(bus.apb_wdata), 32'(v.wdata));
      end
      if (bus.apb_sel && bus.apb_enable) begin
        acc++;
        if (acc == v.waits + 1) begin
          bus.apb_ready = 1'b1;
          bus.apb_rdata = v.cmp_rdata;
        end else begin
          bus.apb_ready = 1'b0;
          bus.apb_rdata = 16'hDEAD;
        end
      end else begin
        bus.apb_ready = 1'b0;
      end
      if (bus.rsp_valid) begin
        got = 1'b1;
        chk({p, "_latency"},   32'(cyc),             32'(v.exp_lat));
        chk({p, "_access"},    32'(acc),             32'(v.waits + 1));
        chk({p, "_rsp_write"}, 32'(bus.rsp_write),   32'(v.wr));
        chk({p, "_rsp_rdata"}, 32'(bus.rsp_rdata),   32'(v.exp_rdata));
        chk({p, "_rsp_to"},    32'(bus.rsp_timeout), 32'd0);
        chk({p, "_sel_drop"},  32'({bus.apb_sel, bus.apb_enable}), 32'd0);
      end
      cyc++;
    end
    if (!got) bound_fail({p, "_rsp"});
    chk({p, "_first_sel"}, 32'(first_sel), 32'd1);
    @(negedge clk);
    chk({p, "_rsp_done"}, 32'(bus.rsp_valid), 32'd0);
    chk({p, "_idle"},     32'(bus.busy),      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rcount, cyc, acc, exp_acc;
    bit got, stable, acc_next, quiet;
    logic [15:0] exp_rd;
    logic        exp_to;
    logic        exp_w [6];
    logic [15:0] exp_d [6];

    vecs[0] = '{1'b1, 8'h10, 16'hA5A5, 0, 16'hBEEF, 16'h0000, 3};
    vecs[1] = '{1'b0, 8'h22, 16'h0000, 2, 16'h1234, 16'h1234, 5};
    vecs[2] = '{1'b0, 8'hFF, 16'h0000, 0, 16'hFFFF, 16'hFFFF, 3};
    vecs[3] = '{1'b1, 8'h00, 16'h0001, 1, 16'h5555, 16'h0000, 4};
    vecs[4] = '{1'b0, 8'h80, 16'h0000, 3, 16'h8001, 16'h8001, 6};

    for (int k = 0; k < 6; k++) begin
      exp_w[k] = (k % 2) == 1;
      exp_d[k] = exp_w[k] ? 16'h0000 : {8'hC0, 8'(8'h40 + k)};
    end

    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0; bus.apb_ready = 1'b0; bus.apb_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // FIFO fill with the response held back, then backpressure and drain.
    bus.rsp_ready = 1'b0;
    bus.apb_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.apb_rdata = {8'hC0, bus.apb_addr};
      bus.cmd_valid = 1'b1; bus.cmd_write = exp_w[k];
      bus.cmd_addr = 8'(8'h40 + k); bus.cmd_wdata = 16'(16'h1000 + k);
      chk($sformatf("full_ready%0d", k), 32'(bus.cmd_ready), 32'd1);
    end
    @(negedge clk);
    bus.cmd_write = exp_w[5]; bus.cmd_addr = 8'h45; bus.cmd_wdata = 16'h1005;
    chk("full_block", 32'(bus.cmd_ready), 32'd0);
    chk("bp_first_valid", 32'(bus.rsp_valid), 32'd1);
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!(bus.rsp_valid && bus.rsp_rdata == exp_d[0] && bus.rsp_write == exp_w[0] &&
            !bus.apb_sel && !bus.cmd_ready)) stable = 1'b0;
    end
    chk("bp_stable", 32'(stable), 32'd1);

    rcount = 0; acc_next = 1'b0;
    for (int c = 0; c < 80 && rcount < 6; c++) begin
      @(negedge clk);
      if (acc_next) begin bus.cmd_valid = 1'b0; acc_next = 1'b0; end
      bus.apb_rdata = {8'hC0, bus.apb_addr};
      if (bus.rsp_valid) begin
        chk($sformatf("drain%0d_write", rcount), 32'(bus.rsp_write), 32'(exp_w[rcount]));
        chk($sformatf("drain%0d_rdata", rcount), 32'(bus.rsp_rdata), 32'(exp_d[rcount]));
        rcount++;
      end
      if (bus.cmd_valid && bus.cmd_ready) acc_next = 1'b1;
      bus.rsp_ready = 1'b1;
    end
    chk("drain_count", 32'(rcount), 32'd6);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("drain_idle", 32'(bus.busy), 32'd0);

    // Stuck completer: abort after 8 ACCESS cycles when the timeout is built in.
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    exp_acc = 8;  exp_to = 1'b1; exp_rd = 16'h0000;
`else
    exp_acc = 21; exp_to = 1'b0; exp_rd = 16'h5A5A;
`endif
    bus.rsp_ready = 1'b0; bus.apb_ready = 1'b0; bus.apb_rdata = 16'hFFFF;
    push_cmd(1'b0, 8'h55, 16'h0000);
    push_cmd(1'b1, 8'h66, 16'h7777);
    acc = 0; got = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (bus.apb_sel && bus.apb_enable) begin
        acc++;
`ifndef APB_CMD_MASTER_TIMEOUT_EN
        if (acc == 21) begin bus.apb_ready = 1'b1; bus.apb_rdata = 16'h5A5A; end
`endif
      end
      if (bus.rsp_valid) got = 1'b1;
    end
    if (!got) bound_fail("to_rsp");
    chk("to_access_cycles", 32'(acc),             32'(exp_acc));
    chk("to_rsp_timeout",   32'(bus.rsp_timeout), 32'(exp_to));
    chk("to_rsp_rdata",     32'(bus.rsp_rdata),   32'(exp_rd));
    chk("to_rsp_write",     32'(bus.rsp_write),   32'd0);
    bus.rsp_ready = 1'b1; bus.apb_ready = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) got = 1'b1;
    end
    if (!got) bound_fail("to_next_rsp");
    chk("to_next_write",   32'(bus.rsp_write),   32'd1);
    chk("to_next_timeout", 32'(bus.rsp_timeout), 32'd0);
    chk("to_next_rdata",   32'(bus.rsp_rdata),   32'd0);
    @(negedge clk);
    chk("to_idle", 32'(bus.busy), 32'd0);

    // Reset during ACCESS with two commands still queued.
    bus.apb_ready = 1'b0;
    push_cmd(1'b0, 8'h11, 16'h0000);
    push_cmd(1'b1, 8'h12, 16'h2222);
    push_cmd(1'b0, 8'h13, 16'h0000);
    got = 1'b0;
    for (cyc = 0; cyc < 20 && !got; cyc++) begin
      @(negedge clk);
      if (bus.apb_sel && bus.apb_enable) got = 1'b1;
    end
    if (!got) bound_fail("rst_access");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("rst_mid");
    quiet = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.apb_sel || bus.busy) quiet = 1'b0;
    end
    chk("rst_mid_quiet", 32'(quiet), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
